// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination lock sequencer.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        PROG    = 2'd2,
        LOCKOUT = 2'd3
    } status_t;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;

    function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that loads LOCKOUT_CYCLES-1 and flags zero; holds at zero.
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 1000,
    localparam int W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= W'(LOCKOUT_CYCLES - 1);
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Combination lock controller: digit entry and compare, fail counting,
// timed lockout and in-place reprogramming of the stored code.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                           NDIGITS        = 6,
    parameter int                           MAX_FAIL       = 3,
    parameter int                           LOCKOUT_CYCLES = 1000,
    parameter logic [NDIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 24'h632914
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 digit_valid,
    input  logic [DIGIT_W-1:0]   digit,
    input  logic                 relock,
    input  logic                 prog_req,
    output logic [1:0]           status,
    output logic [2:0]           digit_count,
    output logic [1:0]           fail_count,
    output logic                 err_pulse
);

    localparam int CW = NDIGITS * DIGIT_W;

    status_t        st;
    logic [CW-1:0]  code;
    logic [CW-1:0]  shadow;
    logic [CW-1:0]  commit_code;
    logic           mis_flag;
    logic [DIGIT_W-1:0] exp_nib;
    logic           cur_mis;
    logic           last_digit;
    logic           verdict_fail;
    logic [1:0]     fail_next;
    logic           lock_trip;
    logic           tmr_zero;
    int             nib_lsb;

    // Digit 0 is the most-significant nibble of the code word.
    always_comb begin
        nib_lsb      = (NDIGITS - 1 - int'(digit_count)) * DIGIT_W;
        exp_nib      = code[nib_lsb +: DIGIT_W];
        cur_mis      = !is_valid_digit(digit) || (digit != exp_nib);
        last_digit   = (digit_count == 3'(NDIGITS - 1));
        verdict_fail = mis_flag || cur_mis;
        fail_next    = fail_count + 2'd1;
        lock_trip    = (st == ENTRY) && digit_valid && last_digit &&
                       verdict_fail && (fail_next == 2'(MAX_FAIL));
        commit_code  = shadow;
        commit_code[DIGIT_W-1:0] = digit;
    end

    lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (lock_trip),
        .en   (st == LOCKOUT),
        .zero (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ENTRY;
            code        <= DEFAULT_CODE;
            shadow      <= '0;
            mis_flag    <= 1'b0;
            digit_count <= '0;
            fail_count  <= '0;
            err_pulse   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            unique case (st)
                ENTRY: if (digit_valid) begin
                    if (last_digit) begin
                        digit_count <= '0;
                        mis_flag    <= 1'b0;
                        if (!verdict_fail) begin
                            st         <= OPEN;
                            fail_count <= '0;
                        end else begin
                            err_pulse  <= 1'b1;
                            fail_count <= fail_next;
                            if (lock_trip) st <= LOCKOUT;
                        end
                    end else begin
                        digit_count <= digit_count + 3'd1;
                        mis_flag    <= mis_flag || cur_mis;
                    end
                end
                OPEN: begin
                    if (relock)
                        st <= ENTRY;
                    else if (prog_req) begin
                        st          <= PROG;
                        digit_count <= '0;
                    end
                end
                PROG: begin
                    if (relock) begin
                        st          <= ENTRY;
                        digit_count <= '0;
                    end else if (digit_valid) begin
                        if (!is_valid_digit(digit)) begin
                            err_pulse   <= 1'b1;
                            st          <= OPEN;
                            digit_count <= '0;
                        end else if (last_digit) begin
                            code        <= commit_code;
                            st          <= ENTRY;
                            digit_count <= '0;
                        end else begin
                            shadow[nib_lsb +: DIGIT_W] <= digit;
                            digit_count <= digit_count + 3'd1;
                        end
                    end
                end
                LOCKOUT: if (tmr_zero) begin
                    st         <= ENTRY;
                    fail_count <= '0;
                end
                default: st <= ENTRY;
            endcase
        end
    end

    assign status = st;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       relock = 1'b0;
    logic       prog_req = 1'b0;
    logic [1:0] status;
    logic [2:0] digit_count;
    logic [1:0] fail_count;
    logic       err_pulse;

    int checks = 0;
    int passes = 0;
    int err_cnt = 0;
    int n;

    lock_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .relock      (relock),
        .prog_req    (prog_req),
        .status      (status),
        .digit_count (digit_count),
        .fail_count  (fail_count),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) err_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic step(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        tick(1);
        digit_valid = 1'b0;
    endtask

    task automatic enter(input logic [23:0] seq);
        for (int i = 0; i < 6; i++) begin
            digit_valid = 1'b1;
            digit = seq[(5-i)*4 +: 4];
            tick(1);
        end
        digit_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_status", status, 0);
        chk("rst_dcnt", digit_count, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_err", err_pulse, 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // default code opens, no error pulse
        n = err_cnt;
        enter(24'h632914);
        chk("open_status", status, 1);
        chk("open_fail", fail_count, 0);
        chk("open_noerr", err_cnt - n, 0);

        // digits ignored while OPEN, relock closes
        step(4'd5);
        chk("open_ignore_dcnt", digit_count, 0);
        relock = 1'b1; tick(1); relock = 1'b0;
        chk("relock", status, 0);

        // three failures -> lockout
        n = err_cnt;
        enter(24'h111111);
        chk("fail1_err", err_pulse, 1);
        chk("fail1_cnt", fail_count, 1);
        chk("fail1_status", status, 0);
        enter(24'h111111);
        chk("fail2_cnt", fail_count, 2);
        enter(24'h111111);
        chk("fail3_status", status, 3);
        chk("fail3_cnt", fail_count, 3);
        tick(1);
        chk("err_pulses", err_cnt - n, 3);

        // lockout duration with digits and controls hammered
        digit_valid = 1'b1; digit = 4'd6; relock = 1'b1; prog_req = 1'b1;
        n = 1;
        while (status == 2'd3 && n < 2000) begin n++; tick(1); end
        digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
        chk("lockout_len", n, 1000);
        chk("lockout_exit", status, 0);
        chk("lockout_fail_clr", fail_count, 0);
        chk("lockout_dcnt", digit_count, 0);

        // reprogram to 123456
        enter(24'h632914);
        chk("open2", status, 1);
        prog_req = 1'b1; tick(1); prog_req = 1'b0;
        chk("prog_status", status, 2);
        chk("prog_dcnt", digit_count, 0);
        enter(24'h123456);
        chk("prog_done", status, 0);
        enter(24'h632914);
        chk("old_code_fails", status, 0);
        chk("old_code_failcnt", fail_count, 1);
        enter(24'h123456);
        chk("new_code_opens", status, 1);
        chk("new_code_failclr", fail_count, 0);

        // invalid digit aborts programming
        prog_req = 1'b1; tick(1); prog_req = 1'b0;
        step(4'd7);
        chk("abort_dcnt1", digit_count, 1);
        step(4'd12);
        chk("abort_err", err_pulse, 1);
        chk("abort_status", status, 1);
        chk("abort_dcnt", digit_count, 0);
        tick(1);
        chk("abort_err_1cyc", err_pulse, 0);

        // relock wins over prog_req
        relock = 1'b1; prog_req = 1'b1; tick(1); relock = 1'b0; prog_req = 1'b0;
        chk("relock_wins", status, 0);
        enter(24'h123456);
        chk("abort_code_kept", status, 1);

        // relock during PROG aborts quietly
        prog_req = 1'b1; tick(1); prog_req = 1'b0;
        step(4'd9);
        relock = 1'b1; tick(1); relock = 1'b0;
        chk("prog_relock_status", status, 0);
        chk("prog_relock_noerr", err_pulse, 0);
        chk("prog_relock_dcnt", digit_count, 0);

        // invalid digit in entry forces a mismatch
        enter(24'h63F914);
        chk("invalid_fail", fail_count, 1);
        chk("invalid_status", status, 0);

        // async reset mid-entry restores default code
        step(4'd1); step(4'd2); step(4'd3);
        chk("mid_dcnt", digit_count, 3);
        #2 rst = 1'b1; #1;
        chk("arst_status", status, 0);
        chk("arst_dcnt", digit_count, 0);
        chk("arst_fail", fail_count, 0);
        tick(1); rst = 1'b0;
        enter(24'h123456);
        chk("arst_new_code_gone", status, 0);
        enter(24'h632914);
        chk("arst_default_opens", status, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
